// File: rtl/control_riesgos_pkg.sv
// Shared processor package for the hazard-control block.
// Holds the hazard FSM state encoding, the default register-index width and
// the width of the post-branch flush counter.
package control_riesgos_pkg;

  // Default register-index width (16 architectural registers).
  localparam int unsigned RegWDefault = 4;

  // Flush counter width; FLUSH_CYC is limited to 1..15.
  localparam int unsigned FlushCntW = 4;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StFlush   = 2'd2
  } state_e;

endpackage

// File: rtl/cmp_riesgo.sv
// Load-use hazard comparator.
// Flags a hazard when the instruction in Execute is a load whose destination
// matches an enabled source register of the instruction in Decode.
// Register 0 is compared like any other register.
// Ports:
//   ra_id, rb_id     : Decode source registers
//   re_a_id, re_b_id : source read enables
//   rd_ex            : Execute destination register
//   mem_re_ex        : Execute instruction is a load
//   hazard           : load-use hazard detected
module cmp_riesgo
  import control_riesgos_pkg::*;
#(
  parameter int unsigned REG_W = RegWDefault
) (
  input  logic [REG_W-1:0] ra_id,
  input  logic [REG_W-1:0] rb_id,
  input  logic             re_a_id,
  input  logic             re_b_id,
  input  logic [REG_W-1:0] rd_ex,
  input  logic             mem_re_ex,
  output logic             hazard
);

  always_comb begin
    hazard = mem_re_ex & ((re_a_id & (ra_id == rd_ex)) | (re_b_id & (rb_id == rd_ex)));
  end

endmodule

// File: rtl/control_riesgos.sv
// Pipeline hazard controller.
// Generates stage-register enables, NOP injection and IF/ID squash for a
// five-stage pipeline. Handles data-memory stalls, taken-branch flushes of
// FLUSH_CYC bubble cycles and load-use stalls, and counts stalled cycles.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   ra_id, rb_id, re_a_id, re_b_id    : Decode source operands
//   rd_ex, mem_re_ex                  : Execute destination / load flag
//   branch_taken_ex                   : Execute branch resolved taken
//   mem_req_mem, mem_ack              : Memory-stage access and completion
//   pc_en, if_id_en, id_ex_en, ex_mem_en : stage enables (1 = advance)
//   nop_mux                           : inject NOP into ID/EX
//   flush                             : squash IF/ID
//   stall_cnt                         : saturating count of cycles with pc_en = 0
module control_riesgos
  import control_riesgos_pkg::*;
#(
  parameter int unsigned REG_W     = RegWDefault,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  ra_id,
  input  logic [REG_W-1:0]  rb_id,
  input  logic              re_a_id,
  input  logic              re_b_id,
  input  logic [REG_W-1:0]  rd_ex,
  input  logic              mem_re_ex,
  input  logic              branch_taken_ex,
  input  logic              mem_req_mem,
  input  logic              mem_ack,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              nop_mux,
  output logic              flush,
  output logic [STAT_W-1:0] stall_cnt
);

  // Remaining FLUSH-state cycles after the branch cycle itself.
  localparam logic [FlushCntW-1:0] FlushLoad = FlushCntW'(FLUSH_CYC - 1);

  state_e               state_q, state_d;
  logic [FlushCntW-1:0] cnt_q, cnt_d;
  logic [STAT_W-1:0]    stall_q;
  logic                 hazard;
  logic                 mem_busy;

  cmp_riesgo #(
    .REG_W (REG_W)
  ) u_cmp_riesgo (
    .ra_id     (ra_id),
    .rb_id     (rb_id),
    .re_a_id   (re_a_id),
    .re_b_id   (re_b_id),
    .rd_ex     (rd_ex),
    .mem_re_ex (mem_re_ex),
    .hazard    (hazard)
  );

  assign mem_busy = mem_req_mem & ~mem_ack;

  always_comb begin
    pc_en     = 1'b1;
    if_id_en  = 1'b1;
    id_ex_en  = 1'b1;
    ex_mem_en = 1'b1;
    nop_mux   = 1'b0;
    flush     = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      StRun: begin
        if (mem_busy) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          state_d   = StMemWait;
        end else if (branch_taken_ex) begin
          // Branch beats a simultaneous load-use hazard: the dependent
          // instruction is squashed anyway.
          flush   = 1'b1;
          nop_mux = 1'b1;
          cnt_d   = FlushLoad;
          state_d = (FLUSH_CYC > 1) ? StFlush : StRun;
        end else if (hazard) begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          nop_mux  = 1'b1;
          state_d  = StRun;
        end
      end

      StMemWait: begin
        if (!mem_ack) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
        end else begin
          if (branch_taken_ex) begin
            flush   = 1'b1;
            nop_mux = 1'b1;
            cnt_d   = FlushLoad;
          end else if (hazard) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            nop_mux  = 1'b1;
          end
          // A flush interrupted by the memory stall resumes with its held count.
          state_d = (cnt_d != '0) ? StFlush : StRun;
        end
      end

      StFlush: begin
        if (mem_busy) begin
          // Counter is held so the stalled cycle does not consume a bubble.
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          state_d   = StMemWait;
        end else begin
          flush   = 1'b1;
          nop_mux = 1'b1;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end
          state_d = (cnt_q <= FlushCntW'(1)) ? StRun : StFlush;
        end
      end

      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase

    // During reset the pipeline advances and fills with bubbles.
    if (rst) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      nop_mux   = 1'b1;
      flush     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_en && (stall_q != {STAT_W{1'b1}})) begin
        stall_q <= stall_q + STAT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_q;

endmodule
